multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter N, default 4: number of independent key channels, legal range 1..16.
REQ-002 Parameter STABLE_CNT, default 1000000: number of consecutive synchronised cycles a new level must hold before it is accepted, minimum 2.
REQ-003 Parameter REPEAT_DELAY, default 50000000: hold cycles before the first auto-repeat pulse (used only with DEBOUNCE_REPEAT_EN).
REQ-004 Parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses (used only with DEBOUNCE_REPEAT_EN).
REQ-005 clk  input  1  single system clock; all state updates on the rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 x  input  N  raw, asynchronous, bouncing key inputs; 1 = pressed.
REQ-008 level  output  N  debounced stable level per channel.
REQ-009 press  output  N  one-cycle pulse per channel on an accepted 0->1 transition, or on an auto-repeat event.
REQ-010 release  output  N  one-cycle pulse per channel on an accepted 1->0 transition.
REQ-011 press_any  output  1  OR of press in the same cycle.
REQ-012 press_idx  output  4  index of the lowest-numbered channel with press=1 this cycle; 0 when press_any=0.

Function
REQ-013 Each channel SHALL pass x[i] through a 2-flop synchroniser; only the second-stage output (xs[i]) feeds the filter.
REQ-014 Each channel SHALL own a counter of width clog2(STABLE_CNT+1); the counter is cleared whenever xs[i] equals level[i].
REQ-015 While xs[i] differs from level[i], the counter SHALL increment by 1 per cycle.
REQ-016 When the counter equals STABLE_CNT-1 and xs[i] still differs, level[i] SHALL take xs[i] at the next edge and the counter SHALL clear.
REQ-017 Any single cycle of xs[i] matching level[i] SHALL restart the count from 0, so glitches shorter than STABLE_CNT cycles never change level.
REQ-018 Latency from a clean x[i] edge to the level[i] change SHALL be exactly STABLE_CNT+2 cycles.
REQ-019 press[i] SHALL be 1 in exactly the cycle in which level[i] first reads 1; release[i] SHALL be 1 in exactly the cycle in which level[i] first reads 0; both outputs are registered.
REQ-020 Channels SHALL be fully independent, and simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-021 press_any and press_idx SHALL be combinational from the registered press vector, so they are valid in the same cycle as press.
REQ-022 Counters SHALL never wrap: the maximum reachable value is STABLE_CNT-1.

Reset
REQ-023 On rstn=0, immediately and regardless of clk: synchronisers, level, counters, press, release and the repeat state SHALL all go to 0.
REQ-024 Reset mid-count SHALL discard partial progress; after rstn rises, a held key is reported as a fresh press after STABLE_CNT+2 cycles.
REQ-025 The first clock edge after rstn deasserts SHALL perform normal operation, with no pulses generated by the reset itself.

Configuration
REQ-026 Macro DEBOUNCE_REPEAT_EN: when defined, each channel SHALL have a repeat counter that is cleared while level[i]=0.
REQ-027 With DEBOUNCE_REPEAT_EN defined and level[i]=1: an extra press[i] pulse SHALL occur REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles until release.
REQ-028 With DEBOUNCE_REPEAT_EN defined, a release SHALL cancel any pending repeat, and no repeat pulse may coincide with the release cycle.
REQ-029 Without DEBOUNCE_REPEAT_EN: no repeat logic SHALL be present, and press pulses only once per accepted press; the REPEAT_* parameters are ignored.

Verification (N=4, STABLE_CNT=16, REPEAT_DELAY=64, REPEAT_PERIOD=32)
REQ-030 Clean press: x[0] goes 0->1 at cycle 10 and is held -> level[0]=1 and press[0]=1 at cycle 28 only; press_idx=0.
REQ-031 Bounce: x[1] toggles every 5 cycles for 60 cycles, then settles at 1 -> no press during bouncing; a single press[1] 18 cycles after the last toggle.
REQ-032 Simultaneous: x[2] and x[3] rise in the same cycle -> press=4'b1100 in one cycle, press_any=1, press_idx=2.
REQ-033 Release: x[0] held at 1, then drops to 0 for 20 cycles -> one release[0] pulse and level[0]=0; a 10-cycle drop produces no release.
REQ-034 Reset mid-count: rstn pulsed low at count 8 with x[0] held at 1 -> all outputs 0 at once; press[0] 18 cycles after rstn rises.
REQ-035 Repeat (macro defined): x[1] held for 200 cycles after acceptance -> press[1] at acceptance, then at +64, +96, +128, +160 and +192; without the macro, a single pulse only.

Source files
------------

// File: rtl/multi_debounce.sv
// multi_debounce
//   N independent key debouncers. Each raw key input is synchronised through
//   two flops, then filtered. A new level is accepted only after it has held
//   for STABLE_CNT consecutive synchronised cycles. Registered one-cycle
//   press/release pulses mark each accepted edge. A combinational priority
//   encoder reports the lowest channel that is pressing in the current cycle.
//
//   Optional feature macro: DEBOUNCE_REPEAT_EN
//     When it is defined, every held key also produces auto-repeat press
//     pulses. The first comes REPEAT_DELAY cycles after the accepted press,
//     and the rest follow every REPEAT_PERIOD cycles. When it is not defined,
//     there is no repeat logic and the REPEAT_* parameters have no effect.
//
// Ports
//   clk_i         system clock, rising edge
//   rstn_i        asynchronous active-low reset
//   x_i           raw bouncing key inputs, 1 = pressed
//   level_o       debounced level per channel
//   press_o       one-cycle pulse on accepted 0->1 (or auto-repeat)
//   release_o     one-cycle pulse on accepted 1->0
//   press_any_o   OR of press_o
//   press_idx_o   lowest channel index with press_o set, 0 when none

module multi_debounce #(
  parameter int N             = 4,
  parameter int STABLE_CNT    = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [N-1:0] x_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic         press_any_o,
  output logic [3:0]   press_idx_o
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  // Elaboration-time parameter sanity checks.
  if (N < 1 || N > 16) begin : g_bad_n
    $error("multi_debounce: N must be in 1..16");
  end
  if (STABLE_CNT < 2) begin : g_bad_stable
    $error("multi_debounce: STABLE_CNT must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("multi_debounce: REPEAT_DELAY and REPEAT_PERIOD must be positive");
  end

  logic [N-1:0]  sync1_q;
  logic [N-1:0]  sync2_q;
  logic [N-1:0]  level_q,   level_d;
  logic [N-1:0]  press_q,   press_d;
  logic [N-1:0]  release_q, release_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

`ifdef DEBOUNCE_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_q [N];
  logic [RW-1:0] rep_d [N];
  // 0 while waiting for the initial delay, 1 once periodic repeating began.
  logic [N-1:0]  periodic_q, periodic_d;
`endif

  // Filter. The counter runs only while the synchronised input disagrees
  // with the accepted level, and it restarts on any agreeing cycle. When it
  // reaches STABLE_CNT-1, the next edge accepts the new level and fires the
  // matching pulse in the same register update. This means the pulse and
  // the new level appear together.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]     = '0;
        level_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
`ifdef DEBOUNCE_REPEAT_EN
    // Repeat timer. It stays cleared while the key is up. It is frozen in
    // the cycle that accepts a release, so a repeat pulse can never collide
    // with the release pulse. After the release, the timer clears.
    for (int i = 0; i < N; i++) begin
      rep_d[i]      = rep_q[i];
      periodic_d[i] = periodic_q[i];
      if (!level_q[i]) begin
        rep_d[i]      = '0;
        periodic_d[i] = 1'b0;
      end else if (!release_d[i]) begin
        if (rep_q[i] == (periodic_q[i] ? REP_NEXT : REP_FIRST)) begin
          rep_d[i]      = '0;
          periodic_d[i] = 1'b1;
          press_d[i]    = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + RW'(1);
        end
      end
    end
`endif
  end

  // State registers. The reset clears everything asynchronously, so the
  // first edge after reset behaves like any other cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef DEBOUNCE_REPEAT_EN
      periodic_q <= '0;
      for (int i = 0; i < N; i++) begin
        rep_q[i] <= '0;
      end
`endif
    end else begin
      sync1_q   <= x_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef DEBOUNCE_REPEAT_EN
      periodic_q <= periodic_d;
      for (int i = 0; i < N; i++) begin
        rep_q[i] <= rep_d[i];
      end
`endif
    end
  end

  // Priority encoder. The loop scans from high to low, so the lowest
  // pressed channel is the one that finally remains.
  always_comb begin
    press_idx_o = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (press_q[i]) begin
        press_idx_o = 4'(i);
      end
    end
  end

  assign press_any_o = |press_q;
  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed testbench for multi_debounce (N=4, STABLE_CNT=16,
// REPEAT_DELAY=64, REPEAT_PERIOD=32). Expected timings are worked out by
// hand. A change applied to x in cycle c shows up on level/press in cycle
// c+18. Repeat pulses are expected only when DEBOUNCE_REPEAT_EN is defined.

module tb_multi_debounce;

  localparam int N       = 4;
  localparam int STABLE  = 16;
  localparam int RDELAY  = 64;
  localparam int RPERIOD = 32;

  logic         clk;
  logic         rstn;
  logic [N-1:0] x;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;
  logic         pressAny;
  logic [3:0]   pressIdx;

  int checks = 0;
  int errors = 0;
  int pressCnt   [N] = '{default: 0};
  int releaseCnt [N] = '{default: 0};

  multi_debounce #(
    .N(N), .STABLE_CNT(STABLE), .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .x_i(x),
    .level_o(level), .press_o(press), .release_o(rel),
    .press_any_o(pressAny), .press_idx_o(pressIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // This block keeps a running count of pulses. Outputs are sampled on the
  // falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      pressCnt[i]   <= pressCnt[i] + int'(press[i]);
      releaseCnt[i] <= releaseCnt[i] + int'(rel[i]);
    end
  end

  // Wait for n rising edges. Afterwards, sit 1 time unit past the last edge.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] newX);
    x = newX;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int snap;
    int snap2;
    logic [N-1:0] expPress;

    rstn = 1'b0;
    x    = '0;
    stepCycles(2);
    checkOutput("reset level", 32'(level), 32'h0);
    checkOutput("reset press", 32'(press), 32'h0);
    checkOutput("reset release", 32'(rel), 32'h0);
    checkOutput("reset any", 32'(pressAny), 32'h0);
    checkOutput("reset idx", 32'(pressIdx), 32'h0);
    rstn = 1'b1;
    stepCycles(3);

    // Clean press on channel 0.
    applyStimulus(4'b0001);
    stepCycles(17);
    checkOutput("clean pre level", 32'(level), 32'h0);
    checkOutput("clean pre press", 32'(press), 32'h0);
    stepCycles(1);
    checkOutput("clean level", 32'(level), 32'h1);
    checkOutput("clean press", 32'(press), 32'h1);
    checkOutput("clean any", 32'(pressAny), 32'h1);
    checkOutput("clean idx", 32'(pressIdx), 32'h0);
    stepCycles(1);
    checkOutput("clean press gone", 32'(press), 32'h0);
    checkOutput("clean any gone", 32'(pressAny), 32'h0);

    // A short 10-cycle drop is filtered out. A 20-cycle drop releases.
    snap = releaseCnt[0];
    applyStimulus(4'b0000);
    stepCycles(10);
    applyStimulus(4'b0001);
    stepCycles(30);
    checkOutput("short drop level", 32'(level), 32'h1);
    checkOutput("short drop release", 32'(releaseCnt[0] - snap), 32'h0);
    applyStimulus(4'b0000);
    stepCycles(17);
    checkOutput("release pre", 32'(rel), 32'h0);
    checkOutput("release pre level", 32'(level), 32'h1);
    stepCycles(1);
    checkOutput("release pulse", 32'(rel), 32'h1);
    checkOutput("release level", 32'(level), 32'h0);
    stepCycles(1);
    checkOutput("release gone", 32'(rel), 32'h0);
    checkOutput("release once", 32'(releaseCnt[0] - snap), 32'h1);

    // A glitch of 15 cycles is rejected. A glitch of 16 cycles is accepted,
    // and then released again.
    snap = pressCnt[2];
    applyStimulus(4'b0100);
    stepCycles(15);
    applyStimulus(4'b0000);
    stepCycles(30);
    checkOutput("glitch15 level", 32'(level), 32'h0);
    checkOutput("glitch15 press", 32'(pressCnt[2] - snap), 32'h0);
    applyStimulus(4'b0100);
    stepCycles(16);
    applyStimulus(4'b0000);
    stepCycles(2);
    checkOutput("glitch16 press", 32'(press), 32'h4);
    checkOutput("glitch16 level", 32'(level), 32'h4);
    stepCycles(16);
    checkOutput("glitch16 release", 32'(rel), 32'h4);
    checkOutput("glitch16 level low", 32'(level), 32'h0);

    // Bounce on channel 1. The input toggles every 5 cycles for 60 cycles,
    // then settles high.
    snap = pressCnt[1];
    for (int t = 0; t < 12; t++) begin
      applyStimulus((t % 2 == 0) ? 4'b0010 : 4'b0000);
      stepCycles(5);
    end
    applyStimulus(4'b0010);
    checkOutput("bounce no press", 32'(pressCnt[1] - snap), 32'h0);
    stepCycles(17);
    checkOutput("bounce pre level", 32'(level), 32'h0);
    stepCycles(1);
    checkOutput("bounce press", 32'(press), 32'h2);
    checkOutput("bounce idx", 32'(pressIdx), 32'h1);
    checkOutput("bounce level", 32'(level), 32'h2);

    // Hold channel 1 for 200 cycles after acceptance.
    snap2 = pressCnt[1];
    for (int k = 1; k <= 200; k++) begin
      stepCycles(1);
      expPress = 4'b0000;
`ifdef DEBOUNCE_REPEAT_EN
      if (k == 64 || k == 96 || k == 128 || k == 160 || k == 192) expPress = 4'b0010;
`endif
      checkOutput($sformatf("hold press k=%0d", k), 32'(press), 32'(expPress));
    end
    applyStimulus(4'b0000);
    stepCycles(18);
    checkOutput("hold release", 32'(rel), 32'h2);
    checkOutput("hold release press", 32'(press), 32'h0);
    checkOutput("hold release level", 32'(level), 32'h0);
`ifdef DEBOUNCE_REPEAT_EN
    checkOutput("hold press total", 32'(pressCnt[1] - snap2), 32'd6);
`else
    checkOutput("hold press total", 32'(pressCnt[1] - snap2), 32'd1);
`endif

    // Channels 2 and 3 rise in the same cycle.
    applyStimulus(4'b1100);
    stepCycles(18);
    checkOutput("simul press", 32'(press), 32'hC);
    checkOutput("simul any", 32'(pressAny), 32'h1);
    checkOutput("simul idx", 32'(pressIdx), 32'h2);
    checkOutput("simul level", 32'(level), 32'hC);
    applyStimulus(4'b1000);
    stepCycles(18);
    checkOutput("simul release2", 32'(rel), 32'h4);
    checkOutput("simul level3", 32'(level), 32'h8);

    // Reset mid-count. Channel 3 is held high, and channel 0 is at count 8.
    applyStimulus(4'b1001);
    stepCycles(10);
    rstn = 1'b0;
    #1;
    checkOutput("rst async level", 32'(level), 32'h0);
    checkOutput("rst async press", 32'(press), 32'h0);
    checkOutput("rst async release", 32'(rel), 32'h0);
    checkOutput("rst async any", 32'(pressAny), 32'h0);
    stepCycles(3);
    rstn = 1'b1;
    snap = pressCnt[0];
    stepCycles(17);
    checkOutput("rst pre press", 32'(press), 32'h0);
    checkOutput("rst pre level", 32'(level), 32'h0);
    stepCycles(1);
    checkOutput("rst fresh press", 32'(press), 32'h9);
    checkOutput("rst fresh level", 32'(level), 32'h9);
    checkOutput("rst fresh idx", 32'(pressIdx), 32'h0);
    stepCycles(1);
    checkOutput("rst press once", 32'(pressCnt[0] - snap), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
